// File: rtl/encoder32x5_batch.sv
// encoder32x5_batch: captures a multi-hot request batch and streams out the index of each set bit
module encoder32x5_batch #(
   parameter int N_REQ     = 32,
   parameter int IDX_W     = 5,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic             req_valid,
   output logic             req_ready,
   output logic [IDX_W-1:0] idx,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [IDX_W:0]   pending_cnt,
   output logic             batch_done
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;
   logic [0:0]       state;
   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] sel;
   logic             xfer;
   logic             last;
   assign req_ready = (state == IDLE) && en;
   assign idx_valid = (state == EMIT);
   assign xfer      = idx_valid && idx_ready;
   assign last      = (pending_cnt == (IDX_W+1)'(1));
   // idx and pending_cnt come only from the registered mask, so they hold while stalled
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (mask[LSB_FIRST ? N_REQ-1-i : i]) idx = IDX_W'(LSB_FIRST ? N_REQ-1-i : i);
   end
   always_comb begin
      pending_cnt = '0;
      for (int i = 0; i < N_REQ; i++) pending_cnt = pending_cnt + (IDX_W+1)'(mask[i]);
   end
   always_comb begin
      sel      = '0;
      sel[idx] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mask       <= '0;
         batch_done <= 1'b0;
      end else begin
         batch_done <= xfer && last;
         if (state == IDLE) begin
            if (req_valid && req_ready && |req) begin
               mask  <= req;
               state <= EMIT;
            end
         end else if (xfer) begin
            mask <= mask & ~sel;
            if (last) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_encoder32x5_batch.sv
// tb_encoder32x5_batch: directed batches, expected indices queued per DUT and checked by a monitor
module tb_encoder32x5_batch;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, idx_ready = 1'b0;
   logic        req_valid = 1'b0, req_valid1 = 1'b0;
   logic [31:0] req = '0;
   logic        req_ready, idx_valid, batch_done, req_ready1, idx_valid1, batch_done1;
   logic [4:0]  idx, idx1;
   logic [5:0]  pending_cnt, pending_cnt1;
   typedef struct packed {logic [4:0] i; logic [5:0] c;} exp_t;
   exp_t q0[$], q1[$];
   exp_t h0, h1;
   logic st0 = 1'b0, st1 = 1'b0;
   int n_vec = 0, n_err = 0, bd0 = 0, bd1 = 0, b0, b1;
   always #5 clk = ~clk;
   encoder32x5_batch #(.LSB_FIRST(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_valid(req_valid), .req_ready(req_ready),
      .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready), .pending_cnt(pending_cnt),
      .batch_done(batch_done));
   encoder32x5_batch #(.LSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_valid(req_valid1), .req_ready(req_ready1),
      .idx(idx1), .idx_valid(idx_valid1), .idx_ready(idx_ready), .pending_cnt(pending_cnt1),
      .batch_done(batch_done1));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   // monitor: pops the expected index on every transfer, checks stability across stalls
   always @(negedge clk) begin
      exp_t e;
      if (batch_done) bd0++;
      if (batch_done1) bd1++;
      if (rst_n && idx_valid && st0) begin
         chk("stall_idx", idx, h0.i);
         chk("stall_cnt", pending_cnt, h0.c);
      end
      if (rst_n && idx_valid1 && st1) begin
         chk("stall_idx1", idx1, h1.i);
         chk("stall_cnt1", pending_cnt1, h1.c);
      end
      st0 = rst_n && idx_valid && !idx_ready;
      st1 = rst_n && idx_valid1 && !idx_ready;
      h0  = '{i: idx, c: pending_cnt};
      h1  = '{i: idx1, c: pending_cnt1};
      if (rst_n && idx_valid && idx_ready) begin
         if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_idx: got %0d expected none", idx);
         end else begin
            e = q0.pop_front();
            chk("idx", idx, e.i);
            chk("cnt", pending_cnt, e.c);
         end
      end
      if (rst_n && idx_valid1 && idx_ready) begin
         if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_idx1: got %0d expected none", idx1);
         end else begin
            e = q1.pop_front();
            chk("idx1", idx1, e.i);
            chk("cnt1", pending_cnt1, e.c);
         end
      end
   end
   task automatic send(input logic [31:0] r, input bit v0, input bit v1);
      int k;
      for (k = 0; k < 50 && !((!v0 || req_ready) && (!v1 || req_ready1)); k++) cyc(1);
      chk("send_timeout", k < 50, 1);
      req = r; req_valid = v0; req_valid1 = v1;
      cyc(1);
      req_valid = 1'b0; req_valid1 = 1'b0;
   endtask
   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && !idx_valid && !idx_valid1) break;
      end
      chk({nm, "_drain"}, k < 300, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      int k;
      #12;
      chk("rst_valid", idx_valid, 0);
      chk("rst_cnt", pending_cnt, 0);
      chk("rst_done", batch_done, 0);
      chk("rst_idx", idx, 0);
      chk("rst_ready_en0", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; en = 1'b1; idx_ready = 1'b1;
      #1 chk("idle_ready", req_ready, 1);
      // 0x25 -> 0, 2, 5
      q0.push_back('{i: 5'd0, c: 6'd3});
      q0.push_back('{i: 5'd2, c: 6'd2});
      q0.push_back('{i: 5'd5, c: 6'd1});
      b0 = bd0;
      send(32'h0000_0025, 1, 0);
      chk("first_valid", idx_valid, 1);
      chk("first_cnt", pending_cnt, 3);
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (batch_done) break;
      end
      chk("done_seen", batch_done, 1);
      chk("done_req_ready", req_ready, 1);
      cyc(3);
      chk("done_once", bd0 - b0, 1);
      chk("q_empty_1", q0.size(), 0);
      // both ends of the vector in both order modes
      q0.push_back('{i: 5'd0, c: 6'd2});
      q0.push_back('{i: 5'd31, c: 6'd1});
      q1.push_back('{i: 5'd31, c: 6'd2});
      q1.push_back('{i: 5'd0, c: 6'd1});
      b0 = bd0; b1 = bd1;
      send(32'h8000_0001, 1, 1);
      wait_idle("ends");
      cyc(2);
      chk("ends_done", bd0 - b0, 1);
      chk("ends_done1", bd1 - b1, 1);
      // full vector with alternating stalls
      for (int i = 0; i < 32; i++) q0.push_back('{i: 5'(i), c: 6'(32 - i)});
      b0 = bd0;
      send(32'hFFFF_FFFF, 1, 0);
      chk("full_cnt", pending_cnt, 32);
      repeat (64) begin
         @(posedge clk); #1;
         idx_ready = !idx_ready;
      end
      idx_ready = 1'b1;
      wait_idle("full");
      cyc(2);
      chk("full_done", bd0 - b0, 1);
      // en gates acceptance only
      idx_ready = 1'b0; en = 1'b0; req = 32'h10; req_valid = 1'b1;
      cyc(3);
      chk("en0_ready", req_ready, 0);
      chk("en0_nocap", idx_valid, 0);
      q0.push_back('{i: 5'd4, c: 6'd1});
      b0 = bd0;
      en = 1'b1;
      cyc(1);
      req_valid = 1'b0; en = 1'b0;
      chk("en1_cap", idx_valid, 1);
      chk("en1_idx", idx, 4);
      cyc(2);
      chk("en0_emit_hold", idx_valid, 1);
      idx_ready = 1'b1;
      wait_idle("en");
      cyc(1);
      chk("en_done", bd0 - b0, 1);
      chk("en0_idle_ready", req_ready, 0);
      // empty batch is dropped
      en = 1'b1; b0 = bd0;
      send(32'h0, 1, 0);
      chk("zero_valid", idx_valid, 0);
      cyc(3);
      chk("zero_valid_later", idx_valid, 0);
      chk("zero_nodone", bd0 - b0, 0);
      chk("zero_ready", req_ready, 1);
      // async reset mid-batch
      q0.push_back('{i: 5'd12, c: 6'd4});
      b0 = bd0;
      send(32'h0000_F000, 1, 0);
      cyc(1);
      idx_ready = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", idx_valid, 0);
      chk("arst_cnt", pending_cnt, 0);
      chk("arst_idx", idx, 0);
      chk("arst_done", batch_done, 0);
      chk("arst_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1; idx_ready = 1'b1;
      cyc(5);
      chk("post_rst_valid", idx_valid, 0);
      chk("post_rst_q", q0.size(), 0);
      chk("post_rst_nodone", bd0 - b0, 0);
      chk("post_rst_ready", req_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
